dsp48a1_sequencer: RTL and testbench
====================================

# dsp48a1_sequencer

Request/response front end that drives a DSP48A1 slice instance (configured A0REG=0, A1REG=1, B0REG=0, B1REG=1, all other registers enabled, SYNC reset). It accepts one operand set per valid/ready handshake and walks the slice through its four clock-enable stages. It then captures BCOUT/M/P/CARRYOUT and returns them on a valid/ready response channel. It sits between datapath control logic and the DSP48A1 and is the only owner of the slice's CE* and RST* pins.

## Interface
- A_DATA_WIDTH, 18, A operand width; B_DATA_WIDTH, 18, B/BCIN width; D_DATA_WIDTH, 18, D width
- C_DATA_WIDTH, 48, C width; P_DATA_WIDTH, 48, P/PCIN width; M_DATA_WIDTH, 36, product width; OPMODE_WIDTH, 8
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- clr  in  1  request a one-cycle reset pulse to the slice (honoured only in IDLE)
- req_valid / req_ready  in / out  1  operation request handshake
- req_a, req_b, req_d, req_c, req_bcin, req_pcin  in  operand widths  operands
- req_carryin  in  1;  req_opmode  in  OPMODE_WIDTH
- rsp_valid / rsp_ready  out / in  1  result handshake
- rsp_p  out  P_DATA_WIDTH;  rsp_m  out  M_DATA_WIDTH;  rsp_bcout  out  B_DATA_WIDTH;  rsp_carryout  out  1
- op_count  out  16  completed responses, wraps at 0xFFFF→0
- dsp_a, dsp_b, dsp_d, dsp_c, dsp_bcin, dsp_pcin, dsp_carryin, dsp_opmode  out  to slice data pins
- dsp_cea, dsp_ceb, dsp_cec, dsp_ced, dsp_cem, dsp_cep, dsp_ceopmode, dsp_cecarryin  out  1 each
- dsp_rst  out  1  fanned to all eight slice RST* pins
- dsp_p, dsp_m, dsp_bcout, dsp_carryout  in  slice outputs

## Operation
- FSM states: RSTDSP, IDLE, ST1, ST2, ST3, ST4, CAP, RESP.
- Any edge with RST=1 → RSTDSP. In that edge, rsp_valid, op_count and operand registers are cleared and the FSM goes to RSTDSP.
- RSTDSP: dsp_rst=1, all CE=0. Next state is IDLE.
- IDLE: req_ready=1 unless clr=1.
  - clr=1 → RSTDSP. clr has priority over a simultaneous req_valid, which is not accepted.
  - req_valid=1 → operands are latched into the dsp_* registers and the FSM goes to ST1.
- ST1: cea, ceb, cec, ced, ceopmode high.
- ST2: cea, ceb high.
- ST3: cem, cecarryin high.
- ST4: cep, cecarryin high.
- CAP: all CE low. Slice outputs are registered into rsp_*. op_count increments. Next state is RESP.
- RESP: rsp_valid=1. rsp_* are held stable. When rsp_ready=1 → IDLE.
- CE/RST outputs are decoded combinationally from the state register. dsp_* data outputs are registered and stay constant from acceptance until the next acceptance.
- clr outside IDLE is ignored and not queued.
- req_ready=0 in every state except IDLE.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_*=0, op_count=0, all dsp_* data=0, all CE=0. dsp_rst=1 in the cycle after reset.
- Acceptance on edge E0 produces CE stages in cycles E0→E1 (ST1) through E3→E4 (ST4).
- Slice outputs are valid after E4 and captured at E5. rsp_valid is high from E5.
- Minimum request-to-request spacing is 6 cycles with rsp_ready tied high. The next req_ready rises after E6.
- RST mid-operation aborts immediately. No response is produced for the aborted operation, and the slice is reset in RSTDSP.

## Configuration
- DSP48A1_SEQ_PCIN_CHAIN_EN defined: dsp_pcin is loaded from the last captured rsp_p instead of req_pcin, which allows accumulation across operations. The last captured rsp_p is 0 after reset or clr.
- DSP48A1_SEQ_PCIN_CHAIN_EN undefined: dsp_pcin is loaded from req_pcin.

## Structure
- Shared package dsp48a1_pkg holds the width constants, the state enum typedef, and OPMODE field localparams: X select [1:0], Z select [3:2], pre-add enable [4], carry [5], pre-sub [6], post-sub [7].
- The testbench reuses dsp48a1_pkg.
- No sub-module. The DSP48A1 is instantiated by the parent alongside this block, not inside it.

## Test plan
- Reset held for 2 cycles → dsp_rst=1 for the cycle after release, op_count=0, rsp_valid=0, then req_ready=1.
- A=3, B=5, OPMODE=8'b0000_0001 → after 5 edges: rsp_m=15, rsp_p=15, rsp_bcout=5, rsp_carryout=0. The CE pattern matches ST1–ST4 exactly.
- D=10, B=2, A=4, OPMODE=8'b0001_0001 → rsp_bcout=12, rsp_m=48, rsp_p=48.
- C=100, A=2, B=3, OPMODE=8'b1000_1101 → rsp_p=94, rsp_carryout=0.
- rsp_ready held low for 10 cycles → rsp_* stable, req_ready=0, the new req_valid is not accepted. clr together with req_valid in IDLE → dsp_rst pulse, no acceptance.
- With DSP48A1_SEQ_PCIN_CHAIN_EN: op1 A=3, B=5, OPMODE=8'b0000_0001 (P=15), then op2 A=1, B=1, OPMODE=8'b0000_0101 → rsp_p=16. RST asserted during ST3 → no response, op_count unchanged.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// Shared widths, sequencer state encoding and OPMODE field positions for the
// DSP48A1 sequencer and anything that talks to the slice.
package dsp48a1_pkg;

   localparam int A_DATA_WIDTH = 18;
   localparam int B_DATA_WIDTH = 18;
   localparam int D_DATA_WIDTH = 18;
   localparam int C_DATA_WIDTH = 48;
   localparam int P_DATA_WIDTH = 48;
   localparam int M_DATA_WIDTH = 36;
   localparam int OPMODE_WIDTH = 8;

   typedef enum logic [2:0] {
      RSTDSP = 3'd0,
      IDLE   = 3'd1,
      ST1    = 3'd2,
      ST2    = 3'd3,
      ST3    = 3'd4,
      ST4    = 3'd5,
      CAP    = 3'd6,
      RESP   = 3'd7
   } seq_state_t;

   localparam int OPM_X_LSB   = 0;
   localparam int OPM_X_MSB   = 1;
   localparam int OPM_Z_LSB   = 2;
   localparam int OPM_Z_MSB   = 3;
   localparam int OPM_PREADD  = 4;
   localparam int OPM_CARRY   = 5;
   localparam int OPM_PRESUB  = 6;
   localparam int OPM_POSTSUB = 7;

   localparam logic [1:0] XSEL_ZERO = 2'd0;
   localparam logic [1:0] XSEL_M    = 2'd1;
   localparam logic [1:0] XSEL_P    = 2'd2;
   localparam logic [1:0] XSEL_DAB  = 2'd3;
   localparam logic [1:0] ZSEL_ZERO = 2'd0;
   localparam logic [1:0] ZSEL_PCIN = 2'd1;
   localparam logic [1:0] ZSEL_P    = 2'd2;
   localparam logic [1:0] ZSEL_C    = 2'd3;

endpackage

// File: rtl/dsp48a1_sequencer.sv
// Handshake front end that steps a DSP48A1 slice through its CE stages and
// returns the captured results. Optional macro: DSP48A1_SEQ_PCIN_CHAIN_EN.
module dsp48a1_sequencer #(
   parameter int A_DATA_WIDTH = dsp48a1_pkg::A_DATA_WIDTH,
   parameter int B_DATA_WIDTH = dsp48a1_pkg::B_DATA_WIDTH,
   parameter int D_DATA_WIDTH = dsp48a1_pkg::D_DATA_WIDTH,
   parameter int C_DATA_WIDTH = dsp48a1_pkg::C_DATA_WIDTH,
   parameter int P_DATA_WIDTH = dsp48a1_pkg::P_DATA_WIDTH,
   parameter int M_DATA_WIDTH = dsp48a1_pkg::M_DATA_WIDTH,
   parameter int OPMODE_WIDTH = dsp48a1_pkg::OPMODE_WIDTH
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    clr,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [A_DATA_WIDTH-1:0] req_a,
   input  logic [B_DATA_WIDTH-1:0] req_b,
   input  logic [D_DATA_WIDTH-1:0] req_d,
   input  logic [C_DATA_WIDTH-1:0] req_c,
   input  logic [B_DATA_WIDTH-1:0] req_bcin,
   input  logic [P_DATA_WIDTH-1:0] req_pcin,
   input  logic                    req_carryin,
   input  logic [OPMODE_WIDTH-1:0] req_opmode,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [P_DATA_WIDTH-1:0] rsp_p,
   output logic [M_DATA_WIDTH-1:0] rsp_m,
   output logic [B_DATA_WIDTH-1:0] rsp_bcout,
   output logic                    rsp_carryout,
   output logic [15:0]             op_count,
   output logic [A_DATA_WIDTH-1:0] dsp_a,
   output logic [B_DATA_WIDTH-1:0] dsp_b,
   output logic [D_DATA_WIDTH-1:0] dsp_d,
   output logic [C_DATA_WIDTH-1:0] dsp_c,
   output logic [B_DATA_WIDTH-1:0] dsp_bcin,
   output logic [P_DATA_WIDTH-1:0] dsp_pcin,
   output logic                    dsp_carryin,
   output logic [OPMODE_WIDTH-1:0] dsp_opmode,
   output logic                    dsp_cea,
   output logic                    dsp_ceb,
   output logic                    dsp_cec,
   output logic                    dsp_ced,
   output logic                    dsp_cem,
   output logic                    dsp_cep,
   output logic                    dsp_ceopmode,
   output logic                    dsp_cecarryin,
   output logic                    dsp_rst,
   input  logic [P_DATA_WIDTH-1:0] dsp_p,
   input  logic [M_DATA_WIDTH-1:0] dsp_m,
   input  logic [B_DATA_WIDTH-1:0] dsp_bcout,
   input  logic                    dsp_carryout
);
   import dsp48a1_pkg::*;

   seq_state_t state;
   logic [P_DATA_WIDTH-1:0] pcin_src;

`ifdef DSP48A1_SEQ_PCIN_CHAIN_EN
   // Accumulator feedback: the slice is cleared by clr, so the chained P is too.
   logic [P_DATA_WIDTH-1:0] pcin_acc;

   always_ff @(posedge CLK) begin
      if (RST || (state == IDLE && clr))
         pcin_acc <= '0;
      else if (state == CAP)
         pcin_acc <= dsp_p;
   end

   assign pcin_src = pcin_acc;
`else
   assign pcin_src = req_pcin;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= RSTDSP;
         rsp_valid    <= 1'b0;
         rsp_p        <= '0;
         rsp_m        <= '0;
         rsp_bcout    <= '0;
         rsp_carryout <= 1'b0;
         op_count     <= '0;
         dsp_a        <= '0;
         dsp_b        <= '0;
         dsp_d        <= '0;
         dsp_c        <= '0;
         dsp_bcin     <= '0;
         dsp_pcin     <= '0;
         dsp_carryin  <= 1'b0;
         dsp_opmode   <= '0;
      end else begin
         case (state)
            RSTDSP: state <= IDLE;
            IDLE: begin
               if (clr)
                  state <= RSTDSP;
               else if (req_valid) begin
                  dsp_a       <= req_a;
                  dsp_b       <= req_b;
                  dsp_d       <= req_d;
                  dsp_c       <= req_c;
                  dsp_bcin    <= req_bcin;
                  dsp_pcin    <= pcin_src;
                  dsp_carryin <= req_carryin;
                  dsp_opmode  <= req_opmode;
                  state       <= ST1;
               end
            end
            ST1: state <= ST2;
            ST2: state <= ST3;
            ST3: state <= ST4;
            ST4: state <= CAP;
            CAP: begin
               rsp_p        <= dsp_p;
               rsp_m        <= dsp_m;
               rsp_bcout    <= dsp_bcout;
               rsp_carryout <= dsp_carryout;
               op_count     <= op_count + 16'd1;
               rsp_valid    <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= RSTDSP;
         endcase
      end
   end

   // A/B are enabled twice so B1 re-samples the pre-adder once D and OPMODE are registered.
   always_comb begin
      req_ready     = 1'b0;
      dsp_rst       = 1'b0;
      dsp_cea       = 1'b0;
      dsp_ceb       = 1'b0;
      dsp_cec       = 1'b0;
      dsp_ced       = 1'b0;
      dsp_cem       = 1'b0;
      dsp_cep       = 1'b0;
      dsp_ceopmode  = 1'b0;
      dsp_cecarryin = 1'b0;
      case (state)
         RSTDSP: dsp_rst = 1'b1;
         IDLE:   req_ready = !clr;
         ST1: begin
            dsp_cea      = 1'b1;
            dsp_ceb      = 1'b1;
            dsp_cec      = 1'b1;
            dsp_ced      = 1'b1;
            dsp_ceopmode = 1'b1;
         end
         ST2: begin
            dsp_cea = 1'b1;
            dsp_ceb = 1'b1;
         end
         ST3: begin
            dsp_cem       = 1'b1;
            dsp_cecarryin = 1'b1;
         end
         ST4: begin
            dsp_cep       = 1'b1;
            dsp_cecarryin = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dsp48a1_sequencer.sv
// Self-checking bench: behavioural DSP48A1 slice driven by the sequencer, with
// a scoreboard of golden results pushed at request acceptance.
module tb_dsp48a1_sequencer;
   import dsp48a1_pkg::*;

   localparam int AW = A_DATA_WIDTH;
   localparam int BW = B_DATA_WIDTH;
   localparam int DW = D_DATA_WIDTH;
   localparam int CW = C_DATA_WIDTH;
   localparam int PW = P_DATA_WIDTH;
   localparam int MW = M_DATA_WIDTH;
   localparam int OW = OPMODE_WIDTH;

   typedef struct {
      logic [PW-1:0] p;
      logic [MW-1:0] m;
      logic [BW-1:0] bc;
      logic          co;
   } exp_t;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic RST = 1'b1, clr = 1'b0, req_valid = 1'b0, rsp_ready = 1'b1;
   logic req_ready, rsp_valid, rsp_carryout, req_carryin = 1'b0;
   logic [AW-1:0] req_a = '0;
   logic [BW-1:0] req_b = '0, req_bcin = '0, rsp_bcout;
   logic [DW-1:0] req_d = '0;
   logic [CW-1:0] req_c = '0;
   logic [PW-1:0] req_pcin = '0, rsp_p;
   logic [OW-1:0] req_opmode = '0;
   logic [MW-1:0] rsp_m;
   logic [15:0]   op_count;
   logic [AW-1:0] dsp_a;
   logic [BW-1:0] dsp_b, dsp_bcin, dsp_bcout;
   logic [DW-1:0] dsp_d;
   logic [CW-1:0] dsp_c;
   logic [PW-1:0] dsp_pcin, dsp_p;
   logic [MW-1:0] dsp_m;
   logic [OW-1:0] dsp_opmode;
   logic dsp_carryin, dsp_carryout, dsp_rst;
   logic dsp_cea, dsp_ceb, dsp_cec, dsp_ced, dsp_cem, dsp_cep, dsp_ceopmode, dsp_cecarryin;

   dsp48a1_sequencer dut (
      .CLK(CLK), .RST(RST), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_d(req_d), .req_c(req_c),
      .req_bcin(req_bcin), .req_pcin(req_pcin), .req_carryin(req_carryin), .req_opmode(req_opmode),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_p(rsp_p), .rsp_m(rsp_m), .rsp_bcout(rsp_bcout), .rsp_carryout(rsp_carryout),
      .op_count(op_count),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
      .dsp_bcin(dsp_bcin), .dsp_pcin(dsp_pcin), .dsp_carryin(dsp_carryin), .dsp_opmode(dsp_opmode),
      .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cec(dsp_cec), .dsp_ced(dsp_ced),
      .dsp_cem(dsp_cem), .dsp_cep(dsp_cep), .dsp_ceopmode(dsp_ceopmode), .dsp_cecarryin(dsp_cecarryin),
      .dsp_rst(dsp_rst),
      .dsp_p(dsp_p), .dsp_m(dsp_m), .dsp_bcout(dsp_bcout), .dsp_carryout(dsp_carryout)
   );

   // ---------------- slice arithmetic ----------------
   function automatic logic [BW-1:0] preadd(input logic [DW-1:0] d, input logic [BW-1:0] b,
                                            input logic [OW-1:0] op);
      if (!op[OPM_PREADD]) return b;
      return op[OPM_PRESUB] ? BW'(d - b) : BW'(d + b);
   endfunction

   function automatic logic [PW-1:0] xsel(input logic [OW-1:0] op, input logic [MW-1:0] m,
                                          input logic [PW-1:0] p, input logic [DW-1:0] d,
                                          input logic [AW-1:0] a, input logic [BW-1:0] b);
      case (op[OPM_X_MSB:OPM_X_LSB])
         XSEL_M:   return {{(PW-MW){m[MW-1]}}, m};
         XSEL_P:   return p;
         XSEL_DAB: return {d[11:0], a, b};
         default:  return '0;
      endcase
   endfunction

   function automatic logic [PW-1:0] zsel(input logic [OW-1:0] op, input logic [PW-1:0] pcin,
                                          input logic [PW-1:0] p, input logic [CW-1:0] c);
      case (op[OPM_Z_MSB:OPM_Z_LSB])
         ZSEL_PCIN: return pcin;
         ZSEL_P:    return p;
         ZSEL_C:    return c;
         default:   return '0;
      endcase
   endfunction

   function automatic logic [PW:0] postadd(input logic [PW-1:0] x, input logic [PW-1:0] z,
                                           input logic cin, input logic sub);
      if (sub) return {1'b0, z} - ({1'b0, x} + {{PW{1'b0}}, cin});
      return {1'b0, z} + {1'b0, x} + {{PW{1'b0}}, cin};
   endfunction

   // ---------------- behavioural slice (A1/B1 only, other regs on) ----------------
   logic [AW-1:0] a1;
   logic [BW-1:0] b1;
   logic [DW-1:0] dreg;
   logic [CW-1:0] creg;
   logic [OW-1:0] opreg;
   logic [MW-1:0] mreg;
   logic [PW-1:0] preg;
   logic          cinreg, coreg;
   logic [PW:0]   post_w;
   logic signed [MW-1:0] prod_w;

   assign prod_w = $signed(a1) * $signed(b1);
   assign post_w = postadd(xsel(opreg, mreg, preg, dreg, a1, b1), zsel(opreg, dsp_pcin, preg, creg),
                           cinreg, opreg[OPM_POSTSUB]);
   assign dsp_p = preg;
   assign dsp_m = mreg;
   assign dsp_bcout = b1;
   assign dsp_carryout = coreg;

   always @(posedge CLK) begin
      if (dsp_rst) begin
         a1 <= '0; b1 <= '0; dreg <= '0; creg <= '0; opreg <= '0;
         mreg <= '0; preg <= '0; cinreg <= 1'b0; coreg <= 1'b0;
      end else begin
         if (dsp_cea) a1 <= dsp_a;
         if (dsp_ceb) b1 <= preadd(dreg, dsp_b, opreg);
         if (dsp_ced) dreg <= dsp_d;
         if (dsp_cec) creg <= dsp_c;
         if (dsp_ceopmode) opreg <= dsp_opmode;
         if (dsp_cem) mreg <= prod_w;
         if (dsp_cep) preg <= post_w[PW-1:0];
         if (dsp_cecarryin) begin
            cinreg <= opreg[OPM_CARRY];
            coreg  <= post_w[PW];
         end
      end
   end

   // ---------------- scoreboard ----------------
   exp_t exp_q[$];
   int n_checks = 0, n_fail = 0;
   int exp_cnt = 0;
   logic [PW-1:0] prev_p = '0;
   logic [7:0] ce_tab [0:4];

   function automatic logic [7:0] ce_vec();
      return {dsp_cea, dsp_ceb, dsp_cec, dsp_ced, dsp_cem, dsp_cep, dsp_ceopmode, dsp_cecarryin};
   endfunction

   task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic [PW-1:0] pcin, input logic cin,
                       input logic [OW-1:0] op);
      int w;
      exp_t e;
      logic [BW-1:0] bp;
      logic signed [MW-1:0] m;
      logic [PW-1:0] pc;
      logic [PW:0] r;
      w = 0;
      @(negedge CLK);
      while (!req_ready && w < 50) begin
         @(negedge CLK);
         w++;
      end
      n_checks++;
      if (!req_ready) begin
         n_fail++;
         $display("FAIL send_wait_ready: req_ready=%b required 1", req_ready);
      end else begin
         req_a = a; req_b = b; req_d = d; req_c = c; req_pcin = pcin;
         req_carryin = cin; req_opmode = op; req_valid = 1'b1;
`ifdef DSP48A1_SEQ_PCIN_CHAIN_EN
         pc = prev_p;
`else
         pc = pcin;
`endif
         bp = preadd(d, b, op);
         m = $signed(a) * $signed(bp);
         r = postadd(xsel(op, m, prev_p, d, a, bp), zsel(op, pc, prev_p, c), op[OPM_CARRY], op[OPM_POSTSUB]);
         e.p = r[PW-1:0]; e.m = m; e.bc = bp; e.co = r[PW];
         prev_p = e.p;
         exp_q.push_back(e);
         @(posedge CLK);
         #1 req_valid = 1'b0;
      end
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin
         @(posedge CLK);
         #1;
         lat++;
      end while (!rsp_valid && lat < 30);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      n_checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_hold: req_ready=%b rsp_valid=%b required 0 0", req_ready, rsp_valid);
      end
      RST = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (dsp_rst !== 1'b1 || ce_vec() !== 8'h00 || req_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_rstdsp: dsp_rst=%b ce=%b req_ready=%b required 1 00000000 0", dsp_rst, ce_vec(), req_ready);
      end
      n_checks++;
      if (op_count !== 16'd0 || rsp_valid !== 1'b0 || rsp_p !== '0 || dsp_a !== '0 || dsp_pcin !== '0) begin
         n_fail++; $display("FAIL reset_values: op_count=%0d rsp_valid=%b rsp_p=%0d dsp_a=%0d required all 0", op_count, rsp_valid, rsp_p, dsp_a);
      end
      @(negedge CLK);
      n_checks++;
      if (dsp_rst !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_idle: dsp_rst=%b req_ready=%b required 0 1", dsp_rst, req_ready);
      end
      exp_cnt = 0; prev_p = '0;
   endtask

   task automatic test_basic();
      logic [AW-1:0] ta [0:2];
      logic [BW-1:0] tb [0:2];
      logic [DW-1:0] td [0:2];
      logic [CW-1:0] tc [0:2];
      logic [OW-1:0] to [0:2];
      logic          tci [0:2];
      ta = '{18'd3, 18'd4, 18'd2};
      tb = '{18'd5, 18'd2, 18'd3};
      td = '{18'd0, 18'd10, 18'd0};
      tc = '{48'd0, 48'd0, 48'd100};
      to = '{8'b0000_0001, 8'b0001_0001, 8'b1000_1101};
      tci = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         int lat;
         exp_t e;
         send(ta[i], tb[i], td[i], tc[i], 48'd0, tci[i], to[i]);
         n_checks++;
         if (dsp_a !== ta[i] || dsp_opmode !== to[i] || dsp_carryin !== tci[i]) begin
            n_fail++; $display("FAIL basic%0d_latch: dsp_a=%0d opmode=%b carryin=%b required %0d %b %b", i, dsp_a, dsp_opmode, dsp_carryin, ta[i], to[i], tci[i]);
         end
         if (i == 0) begin
            lat = 0;
            n_checks++;
            if (ce_vec() !== ce_tab[0]) begin
               n_fail++; $display("FAIL ce_stage0: ce=%b required %b", ce_vec(), ce_tab[0]);
            end
            do begin
               @(posedge CLK);
               #1;
               lat++;
               if (lat <= 4) begin
                  n_checks++;
                  if (ce_vec() !== ce_tab[lat]) begin
                     n_fail++; $display("FAIL ce_stage%0d: ce=%b required %b", lat, ce_vec(), ce_tab[lat]);
                  end
               end
            end while (!rsp_valid && lat < 30);
         end else
            wait_rsp(lat);
         n_checks++;
         if (rsp_valid !== 1'b1 || lat != 5) begin
            n_fail++; $display("FAIL basic%0d_latency: rsp_valid=%b after %0d edges required 1 after 5", i, rsp_valid, lat);
         end
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL basic%0d_scoreboard: queue empty required 1 entry", i);
         end else begin
            e = exp_q.pop_front();
            exp_cnt++;
            if ({rsp_p, rsp_m, rsp_bcout, rsp_carryout} !== {e.p, e.m, e.bc, e.co} || op_count !== 16'(exp_cnt)) begin
               n_fail++;
               $display("FAIL basic%0d_result: p=%0d m=%0d bc=%0d co=%b cnt=%0d required %0d %0d %0d %b %0d",
                        i, rsp_p, rsp_m, rsp_bcout, rsp_carryout, op_count, e.p, e.m, e.bc, e.co, exp_cnt);
            end
         end
         @(posedge CLK);
         #1;
         n_checks++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic%0d_handshake: rsp_valid=%b req_ready=%b required 0 1", i, rsp_valid, req_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      exp_t e;
      logic [PW-1:0] p0;
      logic [MW-1:0] m0;
      rsp_ready = 1'b0;
      send(18'd6, 18'd7, 18'd0, 48'd0, 48'd0, 1'b0, 8'b0000_0001);
      wait_rsp(lat);
      p0 = rsp_p; m0 = rsp_m;
      req_a = 18'd9; req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK);
         #1;
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_p !== p0 || rsp_m !== m0 || req_ready !== 1'b0 || dsp_a !== 18'd6) begin
            n_fail++; $display("FAIL bp_hold%0d: rsp_valid=%b p=%0d m=%0d req_ready=%b dsp_a=%0d required 1 %0d %0d 0 6",
                               i, rsp_valid, rsp_p, rsp_m, req_ready, dsp_a, p0, m0);
         end
      end
      req_valid = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++; $display("FAIL bp_scoreboard: queue empty required 1 entry");
      end else begin
         e = exp_q.pop_front();
         exp_cnt++;
         if ({rsp_p, rsp_m, rsp_bcout, rsp_carryout} !== {e.p, e.m, e.bc, e.co}) begin
            n_fail++; $display("FAIL bp_result: p=%0d m=%0d bc=%0d co=%b required %0d %0d %0d %b", rsp_p, rsp_m, rsp_bcout, rsp_carryout, e.p, e.m, e.bc, e.co);
         end
      end
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || op_count !== 16'(exp_cnt)) begin
         n_fail++; $display("FAIL bp_release: rsp_valid=%b op_count=%0d required 0 %0d", rsp_valid, op_count, exp_cnt);
      end
   endtask

   task automatic test_clr();
      @(negedge CLK);
      clr = 1'b1; req_valid = 1'b1; req_a = 18'd11;
      #1;
      n_checks++;
      if (req_ready !== 1'b0) begin
         n_fail++; $display("FAIL clr_ready: req_ready=%b required 0", req_ready);
      end
      @(posedge CLK);
      #1 clr = 1'b0; req_valid = 1'b0;
      n_checks++;
      if (dsp_rst !== 1'b1 || ce_vec() !== 8'h00 || dsp_a !== 18'd6) begin
         n_fail++; $display("FAIL clr_pulse: dsp_rst=%b ce=%b dsp_a=%0d required 1 00000000 6", dsp_rst, ce_vec(), dsp_a);
      end
      @(posedge CLK);
      #1;
      n_checks++;
      if (dsp_rst !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL clr_end: dsp_rst=%b req_ready=%b required 0 1", dsp_rst, req_ready);
      end
      prev_p = '0;
   endtask

   task automatic test_chain();
      logic [AW-1:0] ca [0:1];
      logic [OW-1:0] co [0:1];
      ca = '{18'd3, 18'd1};
      co = '{8'b0000_0001, 8'b0000_0101};
      for (int i = 0; i < 2; i++) begin
         int lat;
         exp_t e;
         send(ca[i], (i == 0) ? 18'd5 : 18'd1, 18'd0, 48'd0, 48'd1000, 1'b0, co[i]);
         wait_rsp(lat);
         n_checks++;
         if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL chain%0d_rsp: rsp_valid=%b queued=%0d required 1 1", i, rsp_valid, exp_q.size());
         end else begin
            e = exp_q.pop_front();
            exp_cnt++;
            if (rsp_p !== e.p || rsp_m !== e.m || op_count !== 16'(exp_cnt)) begin
               n_fail++; $display("FAIL chain%0d_result: p=%0d m=%0d cnt=%0d required %0d %0d %0d", i, rsp_p, rsp_m, op_count, e.p, e.m, exp_cnt);
            end
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_rst_abort();
      int lat, seen;
      exp_t e;
      send(18'd2, 18'd2, 18'd0, 48'd0, 48'd0, 1'b0, 8'b0000_0001);
      repeat (2) begin
         @(posedge CLK);
         #1;
      end
      n_checks++;
      if (ce_vec() !== ce_tab[2]) begin
         n_fail++; $display("FAIL abort_in_st3: ce=%b required %b", ce_vec(), ce_tab[2]);
      end
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      exp_q.delete();
      exp_cnt = 0; prev_p = '0;
      n_checks++;
      if (dsp_rst !== 1'b1 || rsp_valid !== 1'b0 || op_count !== 16'd0 || rsp_p !== '0) begin
         n_fail++; $display("FAIL abort_reset: dsp_rst=%b rsp_valid=%b op_count=%0d rsp_p=%0d required 1 0 0 0", dsp_rst, rsp_valid, op_count, rsp_p);
      end
      seen = 0;
      repeat (10) begin
         @(posedge CLK);
         #1;
         if (rsp_valid) seen++;
      end
      n_checks++;
      if (seen != 0 || op_count !== 16'd0) begin
         n_fail++; $display("FAIL abort_no_rsp: rsp_valid cycles=%0d op_count=%0d required 0 0", seen, op_count);
      end
      send(18'd5, 18'd5, 18'd0, 48'd0, 48'd0, 1'b0, 8'b0000_0001);
      wait_rsp(lat);
      n_checks++;
      if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
         n_fail++; $display("FAIL recover_rsp: rsp_valid=%b queued=%0d required 1 1", rsp_valid, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         exp_cnt++;
         if (rsp_p !== e.p || rsp_m !== e.m || op_count !== 16'(exp_cnt)) begin
            n_fail++; $display("FAIL recover_result: p=%0d m=%0d cnt=%0d required %0d %0d %0d", rsp_p, rsp_m, op_count, e.p, e.m, exp_cnt);
         end
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      ce_tab[0] = 8'b1111_0010;
      ce_tab[1] = 8'b1100_0000;
      ce_tab[2] = 8'b0000_1001;
      ce_tab[3] = 8'b0000_0101;
      ce_tab[4] = 8'b0000_0000;
      test_reset();
      test_basic();
      test_backpressure();
      test_clr();
      test_chain();
      test_rst_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
